// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
// Holds register addressing, data width and the grant-select encoding.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN       = 32;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_P,
        GNT_L
    } gnt_sel_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bitmap of destination registers awaiting a long-latency result.
// Set and clear may hit the same bit on one edge; set wins. x0 is never busy.
module wb_scoreboard
    import wb_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        busy_next = busy_q;
        if (clr_en) begin
            busy_next = busy_next & ~reg_onehot(clr_idx);
        end
        if (set_en) begin
            busy_next = busy_next | reg_onehot(set_idx);
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline (P)
// and a long-latency unit (L), with a starvation override for L and a busy scoreboard.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN         = wb_port_arbiter_pkg::XLEN,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_p_valid,
    input  logic [REG_ADDR_W-1:0] i_p_rd,
    input  logic [XLEN-1:0]       i_p_data,
    output logic                  o_p_ready,
    input  logic                  i_l_valid,
    input  logic [REG_ADDR_W-1:0] i_l_rd,
    input  logic [XLEN-1:0]       i_l_data,
    output logic                  o_l_ready,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    output logic                  o_wr,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [XLEN-1:0]       o_write_data,
    output logic [NUM_REGS-1:0]   o_busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    gnt_sel_e              gnt_sel;
    logic [3:0]            starve_cnt_q;
    logic [3:0]            starve_cnt_next;

    logic                  wr_q;
    logic                  src_l_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       data_q;

    logic                  sb_set_en;
    logic                  sb_clr_en;
    logic [NUM_REGS-1:0]   sb_busy;

    // Grant select: P by default, L once it has been denied STARVE_LIMIT times in a row.
    always_comb begin
        gnt_sel = GNT_NONE;
        if (rst_n) begin
            if (i_p_valid && i_l_valid) begin
                gnt_sel = (starve_cnt_q == LIMIT) ? GNT_L : GNT_P;
            end else if (i_p_valid) begin
                gnt_sel = GNT_P;
            end else if (i_l_valid) begin
                gnt_sel = GNT_L;
            end
        end
    end

    assign o_p_ready = (gnt_sel == GNT_P);
    assign o_l_ready = (gnt_sel == GNT_L);

    always_comb begin
        starve_cnt_next = '0;
        if (i_l_valid && (gnt_sel != GNT_L)) begin
            starve_cnt_next = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_next;
        end
    end

    // Write command register; rd/data hold between grants, only the enable drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            src_l_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            unique case (gnt_sel)
                GNT_P: begin
                    wr_q    <= (i_p_rd != '0);
                    src_l_q <= 1'b0;
                    rd_q    <= i_p_rd;
                    data_q  <= i_p_data;
                end
                GNT_L: begin
                    wr_q    <= (i_l_rd != '0);
                    src_l_q <= 1'b1;
                    rd_q    <= i_l_rd;
                    data_q  <= i_l_data;
                end
                default: begin
                    wr_q    <= 1'b0;
                    src_l_q <= 1'b0;
                end
            endcase
        end
    end

    // Busy bit drops on the same edge the register file absorbs the L write.
    assign sb_set_en = i_issue_valid && (i_issue_rd != '0);
    assign sb_clr_en = wr_q && src_l_q;

    wb_scoreboard u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (sb_set_en),
        .set_idx (i_issue_rd),
        .clr_en  (sb_clr_en),
        .clr_idx (rd_q),
        .busy    (sb_busy)
    );

    // Outputs are forced low throughout a reset cycle, including a write queued just before it.
    assign o_wr         = wr_q && rst_n;
    assign o_rd         = rst_n ? rd_q : '0;
    assign o_write_data = rst_n ? data_q : '0;
    assign o_busy       = rst_n ? sb_busy : '0;

endmodule
